// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for TotalALU: one request at a time, multi-cycle MULTU, 64-bit response.
// Optional define ALU_SEQ_ZERO_SKIP_EN: MULTU with a zero operand skips the ALU and returns 0.
module alu_op_sequencer #(
    parameter int MUL_CYCLES   = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [5:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_hi,
    output logic [DW-1:0] rsp_lo,
    output logic          rsp_err,
    output logic          alu_reset,
    output logic [5:0]    alu_signal,
    output logic [DW-1:0] alu_dataA,
    output logic [DW-1:0] alu_dataB,
    input  logic [DW-1:0] alu_out
);

    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_NOP   = 6'd63;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_MFHI  = 3'd4;
    localparam logic [2:0] S_MFLO  = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    localparam int CNT_MAX = (MUL_CYCLES > DRAIN_CYCLES) ? MUL_CYCLES : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          bypass;   // EXEC cycle without driving the ALU: error or zero-skipped MULTU
    logic          is_simple;
    logic          is_multu;
    logic          zero_skip;

    assign is_simple = (req_op == OP_AND) || (req_op == OP_OR)  || (req_op == OP_ADD) ||
                       (req_op == OP_SUB) || (req_op == OP_SLT) || (req_op == OP_SLL);
    assign is_multu  = (req_op == OP_MULTU);

`ifdef ALU_SEQ_ZERO_SKIP_EN
    assign zero_skip = (req_a == '0) || (req_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // NOTE: every register below is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bypass     <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_hi     <= '0;
            rsp_lo     <= '0;
            rsp_err    <= 1'b0;
            alu_reset  <= 1'b1;
            alu_signal <= OP_NOP;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
        end else if (alu_reset) begin
            // One clean cycle for the ALU to leave reset before requests are taken.
            alu_reset <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        alu_dataA <= req_a;
                        alu_dataB <= req_b;
                        req_ready <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_hi    <= '0;
                        rsp_lo    <= '0;
                        bypass    <= 1'b0;
                        if (is_simple) begin
                            alu_signal <= req_op;
                            state      <= S_EXEC;
                        end else if (is_multu && !zero_skip) begin
                            alu_signal <= OP_MULTU;
                            cnt        <= CW'(MUL_CYCLES - 1);
                            state      <= S_MUL;
                        end else begin
                            bypass  <= 1'b1;
                            rsp_err <= !is_multu;
                            state   <= S_EXEC;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_EXEC: begin
                    rsp_lo     <= bypass ? '0 : alu_out;
                    rsp_hi     <= '0;
                    alu_signal <= OP_NOP;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        alu_signal <= OP_NOP;
                        cnt        <= CW'(DRAIN_CYCLES - 1);
                        state      <= S_DRAIN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        alu_signal <= OP_MFHI;
                        state      <= S_MFHI;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_MFHI: begin
                    rsp_hi     <= alu_out;
                    alu_signal <= OP_MFLO;
                    state      <= S_MFLO;
                end
                S_MFLO: begin
                    rsp_lo     <= alu_out;
                    alu_signal <= OP_NOP;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    alu_signal <= OP_NOP;
                    rsp_valid  <= 1'b0;
                    req_ready  <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer with a behavioural TotalALU stand-in.
// Honours ALU_SEQ_ZERO_SKIP_EN the same way the design does.
module tb_alu_op_sequencer;

    localparam int DW           = 32;
    localparam int MUL_CYCLES   = 32;
    localparam int DRAIN_CYCLES = 2;
`ifdef ALU_SEQ_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [5:0]    req_op = 6'd0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_hi;
    logic [DW-1:0] rsp_lo;
    logic          rsp_err;
    logic          alu_reset;
    logic [5:0]    alu_signal;
    logic [DW-1:0] alu_dataA;
    logic [DW-1:0] alu_dataB;
    logic [DW-1:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;
    longint last_accept = 0;
    logic [5:0] exp_trace[$];

    alu_op_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
        .alu_reset(alu_reset), .alu_signal(alu_signal), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // TotalALU stand-in: Hi/Lo only load after a full run of MUL_CYCLES multiply cycles.
    logic [DW-1:0] alu_hi_q = '0;
    logic [DW-1:0] alu_lo_q = '0;
    int            mul_run  = 0;
    always @(posedge clk) begin
        if (alu_reset) begin
            mul_run  <= 0;
            alu_hi_q <= '0;
            alu_lo_q <= '0;
        end else if (alu_signal == 6'd25) begin
            if (mul_run == MUL_CYCLES - 1)
                {alu_hi_q, alu_lo_q} <= 64'(alu_dataA) * 64'(alu_dataB);
            mul_run <= mul_run + 1;
        end else begin
            mul_run <= 0;
        end
    end

    always_comb begin
        alu_out = '0;
        case (alu_signal)
            6'd36: alu_out = alu_dataA & alu_dataB;
            6'd37: alu_out = alu_dataA | alu_dataB;
            6'd32: alu_out = alu_dataA + alu_dataB;
            6'd34: alu_out = alu_dataA - alu_dataB;
            6'd42: alu_out = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            6'd0:  alu_out = alu_dataA << alu_dataB[4:0];
            6'd16: alu_out = alu_hi_q;
            6'd18: alu_out = alu_lo_q;
            default: alu_out = '0;
        endcase
    end

    // Reference: expected response and per-cycle Signal trace; trace length is the latency.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic err);
        logic [63:0] prod;
        exp_trace.delete();
        hi = '0;
        lo = '0;
        err = 1'b0;
        case (op)
            6'd36: begin lo = a & b; exp_trace.push_back(op); end
            6'd37: begin lo = a | b; exp_trace.push_back(op); end
            6'd32: begin lo = a + b; exp_trace.push_back(op); end
            6'd34: begin lo = a - b; exp_trace.push_back(op); end
            6'd42: begin lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; exp_trace.push_back(op); end
            6'd0:  begin lo = a << b[4:0]; exp_trace.push_back(op); end
            6'd25: begin
                if (ZERO_SKIP && (a == 0 || b == 0)) begin
                    exp_trace.push_back(6'd63);
                end else begin
                    prod = 64'(a) * 64'(b);
                    hi = prod[63:32];
                    lo = prod[31:0];
                    for (int i = 0; i < MUL_CYCLES; i++) exp_trace.push_back(6'd25);
                    for (int i = 0; i < DRAIN_CYCLES; i++) exp_trace.push_back(6'd63);
                    exp_trace.push_back(6'd16);
                    exp_trace.push_back(6'd18);
                end
            end
            default: begin err = 1'b1; exp_trace.push_back(6'd63); end
        endcase
    endfunction

    // One full transaction from a negedge; returns on the negedge after the response handshake.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] eh, el;
        logic ee;
        int n, to, bad_sig, bad_data, bad_rdy, bad_hold;
        model(op, a, b, eh, el, ee);
        to = 0;
        while (req_ready !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait op=%0d: req_ready=%b, required 1", op, req_ready);
            return;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        last_accept = $time;
        #1;
        req_valid = 1'b0; req_op = 6'($urandom); req_a = $urandom; req_b = $urandom;
        n = 0; bad_sig = 0; bad_data = 0; bad_rdy = 0;
        while (n < 100) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            if (n >= exp_trace.size() || alu_signal !== exp_trace[n]) bad_sig++;
            if (alu_dataA !== a || alu_dataB !== b) bad_data++;
            if (req_ready !== 1'b0) bad_rdy++;
            n++;
        end
        n_checks++;
        if (n != exp_trace.size()) begin
            n_fail++;
            $display("FAIL latency op=%0d: got %0d cycles, required %0d", op, n, exp_trace.size());
        end
        n_checks++;
        if (bad_sig != 0) begin
            n_fail++;
            $display("FAIL signal_trace op=%0d: %0d wrong cycles, required 0", op, bad_sig);
        end
        n_checks++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL data_hold op=%0d: %0d wrong cycles, required 0", op, bad_data);
        end
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL ready_busy op=%0d: req_ready high %0d cycles, required 0", op, bad_rdy);
        end
        if (rsp_valid !== 1'b1) return;
        n_checks++;
        if (rsp_hi !== eh || rsp_lo !== el || rsp_err !== ee || alu_signal !== 6'd63) begin
            n_fail++;
            $display("FAIL response op=%0d a=%h b=%h: hi=%h lo=%h err=%b sig=%0d, required hi=%h lo=%h err=%b sig=63",
                     op, a, b, rsp_hi, rsp_lo, rsp_err, alu_signal, eh, el, ee);
        end
        bad_hold = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hi !== eh || rsp_lo !== el || rsp_err !== ee || req_ready !== 1'b0)
                bad_hold++;
        end
        if (stall > 0) begin
            n_checks++;
            if (bad_hold != 0) begin
                n_fail++;
                $display("FAIL rsp_stable op=%0d: %0d unstable cycles, required 0", op, bad_hold);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_handshake op=%0d: rsp_valid=%b req_ready=%b, required 0 and 1", op, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_hi !== '0 || rsp_lo !== '0 || rsp_err !== 1'b0 ||
            alu_signal !== 6'd63 || alu_dataA !== '0 || alu_dataB !== '0 || alu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rdy=%b vld=%b hi=%h lo=%h err=%b sig=%0d A=%h B=%h alu_rst=%b, required 0 0 0 0 0 63 0 0 1",
                     tag, req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, alu_signal, alu_dataA, alu_dataB, alu_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (alu_reset !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_1: alu_reset=%b req_ready=%b, required 0 and 0", alu_reset, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_2: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_simple_ops();
        logic [5:0] ops[6];
        logic [31:0] a, b;
        ops = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0};
        do_op(6'd32, 32'd5, 32'd7, 0);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_op(ops[i % 6], a, b, $urandom_range(0, 2));
        end
        do_op(6'd42, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(6'd0, 32'd1, 32'd31, 0);
    endtask

    task automatic test_backpressure();
        do_op(6'd34, 32'd3, 32'd5, 5);
    endtask

    task automatic test_multu();
        do_op(6'd25, 32'hFFFF_FFFF, 32'd2, 0);
        for (int i = 0; i < 3; i++) do_op(6'd25, $urandom, $urandom, $urandom_range(0, 2));
        do_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_unsupported();
        logic [5:0] v;
        do_op(6'd7, 32'd11, 32'd22, 1);
        for (int i = 0; i < 3; i++) begin
            v = 6'($urandom_range(0, 63));
            while (v == 6'd0 || v == 6'd25 || v == 6'd32 || v == 6'd34 || v == 6'd36 || v == 6'd37 || v == 6'd42)
                v = 6'($urandom_range(0, 63));
            do_op(v, $urandom, $urandom, 0);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        req_valid = 1'b1; req_op = 6'd25; req_a = 32'd10; req_b = 32'd10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("abort_reset_values");
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_response: rsp_valid seen %0d cycles, required 0", seen);
        end
        do_op(6'd37, 32'h0000_00F0, 32'h0000_000F, 0);
    endtask

    task automatic test_zero_operand();
        do_op(6'd25, 32'd0, 32'd9, 0);
        do_op(6'd25, 32'd1234, 32'd0, 0);
    endtask

    task automatic test_back_to_back();
        longint t0;
        do_op(6'd32, $urandom, $urandom, 0);
        t0 = last_accept;
        do_op(6'd36, $urandom, $urandom, 0);
        n_checks++;
        if (last_accept - t0 != 30) begin
            n_fail++;
            $display("FAIL back_to_back: accept spacing %0d time units, required 30", last_accept - t0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_simple_ops();
        test_backpressure();
        test_multu();
        test_unsupported();
        test_reset_abort();
        test_zero_operand();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Front-end controller for TotalALU. It accepts one operation request at a time over a valid/ready handshake and drives the ALU's Signal/dataA/dataB. It runs the multi-cycle MULTU sequence (multiply, drain, move-Hi, move-Lo) and returns a 64-bit result over a valid/ready response channel. It also owns the ALU's reset sequencing.

Parameters:
MUL_CYCLES, 32, cycles Signal=25 is held for a MULTU
DRAIN_CYCLES, 2, cycles Signal=63 (NOP) is held between MULTU and move-Hi
DW, 32, operand/result width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  6  funct code: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 0 SLL, 25 MULTU
req_a  in  DW  operand A
req_b  in  DW  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hi  out  DW  high word (MULTU Hi, else 0)
rsp_lo  out  DW  low word (MULTU Lo, else ALU Output)
rsp_err  out  1  unsupported op code
alu_reset  out  1  to TotalALU .reset, active-high
alu_signal  out  6  to TotalALU .Signal
alu_dataA  out  DW  to TotalALU .dataA
alu_dataB  out  DW  to TotalALU .dataB
alu_out  in  DW  from TotalALU .Output

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; req_ready=0, rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_err=0, alu_signal=63, alu_dataA=0, alu_dataB=0, alu_reset=1. alu_reset deasserts on the first edge with reset==1. req_ready rises on the following edge.
- States: IDLE, EXEC, MUL, DRAIN, MFHI, MFLO, RESP.
- IDLE: req_ready=1 and alu_signal=63. On req_valid&&req_ready, latch op/a/b and drive alu_dataA/alu_dataB from the latches.
  - Simple op → EXEC.
  - 25 → MUL.
  - Any other code → RESP with rsp_err=1 and hi=lo=0. The ALU is not driven (alu_signal stays 63).
- req_ready=0 in every state other than IDLE.
- EXEC: alu_signal=op for exactly 1 cycle. alu_out is sampled on the edge ending that cycle into rsp_lo, with rsp_hi=0 → RESP. Latency is 1 cycle from accept edge to rsp_valid.
- MUL: alu_signal=25 for MUL_CYCLES cycles, counted by an internal down-counter loaded at accept → DRAIN.
- DRAIN: alu_signal=63 for DRAIN_CYCLES cycles → MFHI.
- MFHI: alu_signal=16 for 1 cycle; alu_out sampled into rsp_hi at the ending edge → MFLO.
- MFLO: alu_signal=18 for 1 cycle; alu_out sampled into rsp_lo → RESP.
- MULTU latency: MUL_CYCLES+DRAIN_CYCLES+2 cycles (36 by default).
- alu_dataA/alu_dataB are held constant from accept until leaving MFLO/EXEC.
- RESP: rsp_valid=1, alu_signal=63. rsp_hi/lo/err are stable until rsp_valid&&rsp_ready, then → IDLE. rsp_valid deasserts that edge. No request is accepted in the same cycle as a response handshake; minimum simple-op throughput is 1 op / 3 cycles.
- rsp_err is cleared on every new accept.
- Reset mid-operation: abort from any state to the reset values above (alu_reset pulses). No response is emitted for the aborted request.
- The counter never underflows. MUL_CYCLES and DRAIN_CYCLES ≥1 are legal; 0 is not supported.
- SLL shift amount is whatever the ALU takes from dataB; the sequencer does not reformat operands.

Optional Feature:
ALU_SEQ_ZERO_SKIP_EN
- Defined: a MULTU with req_a==0 or req_b==0 bypasses MUL/DRAIN/MFHI/MFLO. It goes directly to RESP with hi=lo=0 after 1 cycle, and alu_signal stays 63.
- Undefined: every MULTU runs the full sequence regardless of operand values.

Test Plan:
- ADD a=5 b=7, rsp_ready=1 → alu_signal=32 for 1 cycle; rsp_valid 1 cycle after accept; rsp_lo=12, rsp_hi=0, rsp_err=0.
- SUB a=3 b=5 with rsp_ready held 0 for 5 cycles → rsp_lo=0xFFFFFFFE held stable and rsp_valid=1 throughout; req_ready=0 until the handshake, then 1 the next cycle.
- MULTU a=0xFFFFFFFF b=2 → alu_signal trace: 25×32, 63×2, 16×1, 18×1, then 63. rsp_valid at cycle 36: rsp_hi=1, rsp_lo=0xFFFFFFFE.
- req_op=7 → rsp_err=1, hi=lo=0 after 1 cycle; alu_signal never leaves 63.
- MULTU a=10 b=10 with reset=0 for 1 cycle at cycle 10 → alu_reset=1, rsp_valid never set. A subsequent OR a=0xF0 b=0x0F returns rsp_lo=0xFF.
- With ALU_SEQ_ZERO_SKIP_EN: MULTU a=0 b=9 → rsp_valid after 1 cycle, hi=lo=0, no Signal=25 issued. Without the macro, the same stimulus takes 36 cycles and returns hi=lo=0.
